vga_pixel_fetch: RTL

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: framebuffer read engine that keeps a pixel FIFO topped up for scan-out.
// Define VGA_FETCH_STATS_EN to add the saturating underflow_count output.
module vga_pixel_fetch #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] FB_BASE    = 32'h0,
    parameter int unsigned FB_PIXELS  = 307200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        frame_start,
    input  logic        active,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pixel,
`ifdef VGA_FETCH_STATS_EN
    output logic        underflow,
    output logic [15:0] underflow_count
`else
    output logic        underflow
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] LAST_IDX = 32'(FB_PIXELS - 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [31:0]   idx;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [15:0]   discard;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   fifo_mem [FIFO_DEPTH];

    logic [CW:0]   in_flight;
    logic [15:0]   pending;
    logic          xfer;
    logic          push;
    logic          pop;
    logic          do_pop;
    logic          empty_pop;
    logic          discarding;

    always_comb begin
        in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
        mem_req    = (state == RUN) && !frame_start && (in_flight < DEPTH_LIM);
        mem_addr   = FB_BASE + idx;
        xfer       = mem_req && mem_ready;
        discarding = (discard != 16'd0);
        push       = mem_rvalid && !discarding;
        pop        = pix_en && active;
        do_pop     = pop && (state != IDLE) && (fifo_count != '0);
        empty_pop  = pop && !do_pop;
        pending    = discard + 16'(outstanding) + 16'(xfer);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            pixel       <= '0;
            underflow   <= 1'b0;
        end else begin
            if (frame_start)
                state <= RUN;
            else if (state == RUN && xfer && idx == LAST_IDX)
                state <= DONE;

            if (frame_start)
                idx <= '0;
            else if (xfer)
                idx <= (idx == LAST_IDX) ? '0 : idx + 32'd1;

            if (do_pop)
                pixel <= fifo_mem[rd_ptr];
            else if (pix_en)
                pixel <= '0;

            underflow <= empty_pop || (underflow && !frame_start);

            if (frame_start) begin
                // Everything still in flight belongs to the old frame.
                discard     <= (mem_rvalid && pending != 16'd0) ?
                               pending - 16'd1 : pending;
                outstanding <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
            end else begin
                if (mem_rvalid && discarding)
                    discard <= discard - 16'd1;

                if (xfer && !push)
                    outstanding <= outstanding + CW'(1);
                else if (push && !xfer)
                    outstanding <= outstanding - CW'(1);

                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);

                if (push && !do_pop)
                    fifo_count <= fifo_count + CW'(1);
                else if (do_pop && !push)
                    fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !frame_start)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

`ifdef VGA_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            underflow_count <= '0;
        else if (frame_start)
            underflow_count <= {15'd0, empty_pop};
        else if (empty_pop && underflow_count != 16'hFFFF)
            underflow_count <= underflow_count + 16'd1;
    end
`endif

endmodule
